// File: rtl/inst_fetch_sram_pkg.sv
// Shared CPU definitions for the instruction-fetch path: fetch FSM states,
// base SRAM geometry and the reset program counter.
package inst_fetch_sram_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } fetch_state_e;

    localparam int          SRAM_ADDR_W  = 20;
    localparam logic [9:0]  BASE_RAM_TAG = 10'h200;
    localparam logic [31:0] RESET_PC     = 32'h8000_0000;

    // A fetch is legal only when word aligned and inside the base SRAM window.
    function automatic logic fetch_addr_ok(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc[31:22] == BASE_RAM_TAG);
    endfunction

endpackage

// File: rtl/inst_fetch_sram_if.sv
// Fetch-side bundle: PC request, pipeline control, IF/ID response and the
// base SRAM read port. The slave modport is the fetch unit itself.
interface inst_fetch_sram_if;
    import inst_fetch_sram_pkg::*;

    logic [31:0]            pc_i;
    logic                   flush_i;
    logic                   conflict_i;
    logic                   inval_i;
    logic                   stallreq_o;
    logic [31:0]            inst_o;
    logic                   inst_valid_o;
    logic                   addr_err_o;
    logic [SRAM_ADDR_W-1:0] sram_addr_o;
    logic                   sram_ce_n_o;
    logic                   sram_oe_n_o;
    logic                   sram_we_n_o;
    logic [3:0]             sram_be_n_o;
    logic [31:0]            sram_data_i;

    modport slave (
        input  pc_i, flush_i, conflict_i, inval_i, sram_data_i,
        output stallreq_o, inst_o, inst_valid_o, addr_err_o,
               sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

    modport master (
        output pc_i, flush_i, conflict_i, inval_i, sram_data_i,
        input  stallreq_o, inst_o, inst_valid_o, addr_err_o,
               sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

endinterface

// File: rtl/inst_fetch_sram.sv
// Instruction-fetch responder on the base SRAM. Each PC address is read
// with WAIT_CYCLES extra read cycles; the PC is stalled until the word (or
// an address error) is presented for one DONE cycle.
// Optional feature: define INST_BUF_EN to add a one-entry instruction buffer
// that serves repeated fetches of the same word without an SRAM access.
module inst_fetch_sram
    import inst_fetch_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_sram_if.slave  bus
);

    fetch_state_e           state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            inst_q, inst_d;
    logic                   err_q, err_d;
    logic                   strobe_q, strobe_d;   // 1 = SRAM read strobes active
    logic                   refill;               // SRAM read completes this cycle
    logic                   buf_hit;
    logic [31:0]            buf_data;

    // Next-state, read sequencing and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        err_d    = err_q;
        strobe_d = strobe_q;
        refill   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A buffer hit needs no SRAM, so conflict does not block it.
                if (buf_hit) begin
                    inst_d  = buf_data;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (!bus.conflict_i) begin
                    if (!fetch_addr_ok(bus.pc_i)) begin
                        inst_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d   = bus.pc_i[SRAM_ADDR_W+1:2];
                        strobe_d = 1'b1;
                        cnt_d    = 3'(WAIT_CYCLES);
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.flush_i) begin
                    strobe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    inst_d   = bus.sram_data_i;
                    err_d    = 1'b0;
                    strobe_d = 1'b0;
                    refill   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops the strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
        end
    end

`ifdef INST_BUF_EN
    logic                   buf_vld_q;
    logic [SRAM_ADDR_W-1:0] buf_tag_q;
    logic [31:0]            buf_data_q;

    // A store (inval) must never be shadowed by a stale hit in the same cycle.
    assign buf_hit  = buf_vld_q && !bus.inval_i && fetch_addr_ok(bus.pc_i) &&
                      (buf_tag_q == bus.pc_i[SRAM_ADDR_W+1:2]);
    assign buf_data = buf_data_q;

    // Last-fetch buffer: refilled by each completed read, dropped on inval/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
        end else if (bus.inval_i || bus.flush_i) begin
            buf_vld_q <= 1'b0;
        end else if (refill) begin
            buf_vld_q  <= 1'b1;
            buf_tag_q  <= addr_q;
            buf_data_q <= bus.sram_data_i;
        end
    end
`else
    logic unused_nobuf;

    assign buf_hit      = 1'b0;
    assign buf_data     = '0;
    assign unused_nobuf = bus.inval_i ^ refill;
`endif

    assign bus.stallreq_o   = !rst && (state_q != S_DONE);
    assign bus.inst_valid_o = (state_q == S_DONE) && !bus.flush_i;
    assign bus.addr_err_o   = (state_q == S_DONE) && err_q && !bus.flush_i;
    assign bus.inst_o       = inst_q;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_ce_n_o  = !strobe_q;
    assign bus.sram_oe_n_o  = !strobe_q;
    assign bus.sram_we_n_o  = 1'b1;
    assign bus.sram_be_n_o  = {4{!strobe_q}};

endmodule

// File: tb/tb_inst_fetch_sram.sv
// Bench for inst_fetch_sram: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_inst_fetch_sram;
    import inst_fetch_sram_pkg::*;

    localparam int W = 1;
`ifdef INST_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] noise = 32'h0;
    int n_chk = 0;
    int n_fail = 0;

    inst_fetch_sram_if bus();

    inst_fetch_sram #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SRAM contents: word 0 holds 32'h3C011234, others a simple hash.
    function automatic logic [31:0] mem(input logic [19:0] a);
        return 32'h3C011234 ^ ({12'h0, a} * 32'h01000193);
    endfunction

    // Data bus carries junk whenever the chip is not selected.
    always @(posedge clk) noise <= $urandom;
    assign bus.sram_data_i = bus.sram_ce_n_o ? noise : mem(bus.sram_addr_o);

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          rd_left = 0;     // SRAM read cycles still to go
    logic        dlv = 1'b0;      // this cycle presents a result
    logic        dlv_err = 1'b0;
    logic [31:0] dlv_word = 32'h0;
    logic [19:0] rd_addr = 20'h0;
    logic        bvld = 1'b0;
    logic [19:0] btag = 20'h0;
    logic [31:0] bdata = 32'h0;

    always @(negedge clk) begin : model
        logic [31:0] pc;
        logic ok, hit, clr;
        if (rst) begin
            chkb("rst_stall", bus.stallreq_o, 1'b0);
            chkb("rst_ce_n", bus.sram_ce_n_o, 1'b1);
            chkb("rst_valid", bus.inst_valid_o, 1'b0);
            chkb("rst_err", bus.addr_err_o, 1'b0);
            chkw("rst_inst", bus.inst_o, 32'h0);
            rd_left = 0;
            dlv = 1'b0;
            bvld = 1'b0;
        end else begin
            if (dlv) begin
                chkb("m_stall", bus.stallreq_o, 1'b0);
                chkb("m_valid", bus.inst_valid_o, !bus.flush_i);
                chkb("m_err", bus.addr_err_o, dlv_err && !bus.flush_i);
                chkw("m_inst", bus.inst_o, dlv_word);
                chkb("m_ce_n", bus.sram_ce_n_o, 1'b1);
                chkw("m_be_n", {28'h0, bus.sram_be_n_o}, 32'hF);
            end else if (rd_left > 0) begin
                chkb("m_stall", bus.stallreq_o, 1'b1);
                chkb("m_valid", bus.inst_valid_o, 1'b0);
                chkb("m_err", bus.addr_err_o, 1'b0);
                chkb("m_ce_n", bus.sram_ce_n_o, 1'b0);
                chkb("m_oe_n", bus.sram_oe_n_o, 1'b0);
                chkw("m_be_n", {28'h0, bus.sram_be_n_o}, 32'h0);
                chkw("m_addr", {12'h0, bus.sram_addr_o}, {12'h0, rd_addr});
            end else begin
                chkb("m_stall", bus.stallreq_o, 1'b1);
                chkb("m_valid", bus.inst_valid_o, 1'b0);
                chkb("m_err", bus.addr_err_o, 1'b0);
                chkb("m_ce_n", bus.sram_ce_n_o, 1'b1);
                chkb("m_oe_n", bus.sram_oe_n_o, 1'b1);
                chkw("m_be_n", {28'h0, bus.sram_be_n_o}, 32'hF);
            end
            chkb("m_we_n", bus.sram_we_n_o, 1'b1);

            pc  = bus.pc_i;
            ok  = (pc[1:0] == 2'b00) && (pc[31:22] == 10'h200);
            clr = BUF && (bus.inval_i || bus.flush_i);
            if (dlv) begin
                dlv = 1'b0;
            end else if (rd_left > 0) begin
                if (bus.flush_i) begin
                    rd_left = 0;
                end else if (rd_left == 1) begin
                    rd_left  = 0;
                    dlv      = 1'b1;
                    dlv_err  = 1'b0;
                    dlv_word = mem(rd_addr);
                    if (BUF && !clr) begin
                        bvld  = 1'b1;
                        btag  = rd_addr;
                        bdata = mem(rd_addr);
                    end
                end else begin
                    rd_left--;
                end
            end else begin
                hit = BUF && ok && bvld && (btag == pc[21:2]) && !bus.inval_i;
                if (hit) begin
                    dlv = 1'b1; dlv_err = 1'b0; dlv_word = bdata;
                end else if (!bus.conflict_i) begin
                    if (!ok) begin
                        dlv = 1'b1; dlv_err = 1'b1; dlv_word = 32'h0;
                    end else begin
                        rd_left = W + 1;
                        rd_addr = pc[21:2];
                    end
                end
            end
            if (clr) bvld = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Run until the DONE cycle (stall released) and stop in the next IDLE.
    task automatic wait_done(input int maxc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            neg();
            if (bus.stallreq_o === 1'b0) seen = 1'b1;
            step();
        end
        chkb("wait_done", seen, 1'b1);
    endtask

    initial begin
        bus.pc_i       = RESET_PC;
        bus.flush_i    = 1'b0;
        bus.conflict_i = 1'b0;
        bus.inval_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal fetch of the reset PC, WAIT_CYCLES = 1.
        neg(); chkb("t1_c0_ce_n", bus.sram_ce_n_o, 1'b1); chkb("t1_c0_stall", bus.stallreq_o, 1'b1); step();
        neg(); chkb("t1_c1_ce_n", bus.sram_ce_n_o, 1'b0); chkw("t1_c1_addr", {12'h0, bus.sram_addr_o}, 32'h0); step();
        neg(); chkb("t1_c2_oe_n", bus.sram_oe_n_o, 1'b0); chkb("t1_c2_valid", bus.inst_valid_o, 1'b0); step();
        neg(); chkb("t1_c3_valid", bus.inst_valid_o, 1'b1); chkw("t1_c3_inst", bus.inst_o, 32'h3C011234);
        chkb("t1_c3_stall", bus.stallreq_o, 1'b0); chkb("t1_c3_ce_n", bus.sram_ce_n_o, 1'b1); step();

        // Misaligned fetch: no SRAM access, error in one cycle.
        bus.pc_i = 32'h8000_0002;
        neg(); chkb("t2_c0_ce_n", bus.sram_ce_n_o, 1'b1); step();
        neg(); chkb("t2_valid", bus.inst_valid_o, 1'b1); chkb("t2_err", bus.addr_err_o, 1'b1);
        chkw("t2_inst", bus.inst_o, 32'h0); chkb("t2_ce_n", bus.sram_ce_n_o, 1'b1); step();

        // Flush during the second READ cycle, then refetch from new PC.
        bus.pc_i = 32'h8000_0010;
        neg(); step();
        neg(); chkw("t3_addr", {12'h0, bus.sram_addr_o}, 32'h4); step();
        bus.flush_i = 1'b1;
        neg(); chkb("t3_flush_valid", bus.inst_valid_o, 1'b0); step();
        bus.flush_i = 1'b0;
        bus.pc_i = 32'h8000_0020;
        neg(); chkb("t3_after_ce_n", bus.sram_ce_n_o, 1'b1); chkb("t3_after_valid", bus.inst_valid_o, 1'b0);
        chkb("t3_after_stall", bus.stallreq_o, 1'b1); step();
        neg(); chkb("t3_new_ce_n", bus.sram_ce_n_o, 1'b0); chkw("t3_new_addr", {12'h0, bus.sram_addr_o}, 32'h8); step();
        wait_done(8);

        // Conflict holds the fetch in IDLE for three cycles.
        bus.conflict_i = 1'b1;
        bus.pc_i = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            neg(); chkb("t4_conf_ce_n", bus.sram_ce_n_o, 1'b1); chkb("t4_conf_stall", bus.stallreq_o, 1'b1); step();
        end
        bus.conflict_i = 1'b0;
        neg(); chkb("t4_idle_ce_n", bus.sram_ce_n_o, 1'b1); step();
        neg(); chkb("t4_rd_ce_n", bus.sram_ce_n_o, 1'b0); chkw("t4_rd_addr", {12'h0, bus.sram_addr_o}, 32'h10); step();
        wait_done(8);

`ifdef INST_BUF_EN
        // Same PC again: buffer hit, no SRAM strobe, two cycles.
        neg(); chkb("t5_hit_ce_n", bus.sram_ce_n_o, 1'b1); step();
        neg(); chkb("t5_hit_valid", bus.inst_valid_o, 1'b1); chkw("t5_hit_inst", bus.inst_o, mem(20'h10));
        chkb("t5_hit_ce_n2", bus.sram_ce_n_o, 1'b1); step();
        // Invalidate before the refetch: full SRAM read.
        bus.inval_i = 1'b1;
        neg(); chkb("t5_inv_idle", bus.sram_ce_n_o, 1'b1); step();
        bus.inval_i = 1'b0;
        neg(); chkb("t5_inv_ce_n", bus.sram_ce_n_o, 1'b0); step();
        wait_done(8);
`else
        // No buffer: refetch of the same PC with inval goes to SRAM.
        bus.inval_i = 1'b1;
        neg(); chkb("t5_idle_ce_n", bus.sram_ce_n_o, 1'b1); step();
        bus.inval_i = 1'b0;
        neg(); chkb("t5_rd_ce_n", bus.sram_ce_n_o, 1'b0); step();
        wait_done(8);
`endif

        // Out-of-range fetch.
        bus.pc_i = 32'h0040_0000;
        neg(); step();
        neg(); chkb("t6_err", bus.addr_err_o, 1'b1); chkb("t6_valid", bus.inst_valid_o, 1'b1);
        chkw("t6_inst", bus.inst_o, 32'h0); step();

        // Reset in the middle of a read acts without a clock edge.
        bus.pc_i = 32'h8000_0100;
        neg(); step();
        chkb("t7_pre_ce_n", bus.sram_ce_n_o, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chkb("t7_rst_ce_n", bus.sram_ce_n_o, 1'b1);
        chkb("t7_rst_oe_n", bus.sram_oe_n_o, 1'b1);
        chkw("t7_rst_be_n", {28'h0, bus.sram_be_n_o}, 32'hF);
        chkb("t7_rst_valid", bus.inst_valid_o, 1'b0);
        chkb("t7_rst_stall", bus.stallreq_o, 1'b0);
        step(); step();
        rst = 1'b0;
        bus.pc_i = RESET_PC;
        neg(); chkb("t7_post_ce_n", bus.sram_ce_n_o, 1'b1); chkb("t7_post_stall", bus.stallreq_o, 1'b1); step();
        neg(); chkb("t7_post_rd", bus.sram_ce_n_o, 1'b0); chkw("t7_post_addr", {12'h0, bus.sram_addr_o}, 32'h0); step();
        wait_done(8);

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)
                bus.pc_i = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
            else if (r < 20)
                bus.pc_i = $urandom;
            else
                bus.pc_i = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2);
            bus.flush_i    = ($urandom_range(0, 99) < 8);
            bus.conflict_i = ($urandom_range(0, 99) < 25);
            bus.inval_i    = ($urandom_range(0, 99) < 8);
            step();
        end
        bus.flush_i    = 1'b0;
        bus.conflict_i = 1'b0;
        bus.inval_i    = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
